// File: rtl/lab3_pkg.sv
// Shared definitions for the Lab 3 self-test sequencer.
//   state_t   : sequencer states (IDLE, SETTLE, SAMPLE, FINISH)
//   VEC_COUNT : number of input vectors swept (all 4-bit combinations)
//   VEC_W     : width of a vector index
//   RES_W     : width of one captured result word {out1,out2,out3}
package lab3_pkg;

    localparam int VEC_COUNT = 16;
    localparam int VEC_W     = 4;
    localparam int RES_W     = 3;

    localparam logic [VEC_W-1:0] LAST_VEC = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    // A vector fails when any bit of the captured word differs from golden,
    // so a vector with several wrong bits still counts as one error.
    function automatic logic word_mismatch(input logic [RES_W-1:0] got,
                                           input logic [RES_W-1:0] want);
        return (got != want);
    endfunction

endpackage

// File: rtl/lab3_golden.sv
// Golden model of the Lab 3 four-input logic unit.
//   idx      in  4 : vector index, a=idx[3], b=idx[2], c=idx[1], d=idx[0]
//   expected out 3 : {g1,g2,g3} the unit must produce for that vector
module lab3_golden
    import lab3_pkg::*;
(
    input  logic [VEC_W-1:0] idx,
    output logic [RES_W-1:0] expected
);

    logic a_s;
    logic b_s;
    logic c_s;
    logic d_s;
    logic g1_s;
    logic g2_s;
    logic g3_s;

    // Expected unit outputs from the reference equations.
    always_comb begin
        a_s      = idx[3];
        b_s      = idx[2];
        c_s      = idx[1];
        d_s      = idx[0];
        g2_s     = (a_s & c_s) | (b_s & d_s);
        g3_s     = (a_s | ~c_s) & (~b_s | d_s);
        g1_s     = g2_s | g3_s;
        expected = {g1_s, g2_s, g3_s};
    end

endmodule

// File: rtl/lab3_sweep_ctrl.sv
// Self-test sequencer for the Lab 3 four-input logic unit. On start it walks
// all 16 input vectors, holds each for SETTLE_CYCLES, samples the unit
// outputs, compares them with the golden model and records the results.
// Ports:
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   start, stop           : begin a sweep (IDLE only) / abort a running sweep
//   a_o, b_o, c_o, d_o    : unit inputs, the current vector index bits 3..0
//   out1_i, out2_i, out3_i: unit outputs
//   busy, done, aborted   : sweep running / completion pulse / abort pulse
//   pass                  : no mismatches, valid from done until next start
//   err_count             : number of mismatching vectors (0..16)
//   first_fail_vec/valid  : lowest failing vector and its valid flag
//   rd_addr, rd_data      : combinational read port of the 16x3 result file
module lab3_sweep_ctrl
    import lab3_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    output logic             d_o,
    input  logic             out1_i,
    input  logic             out2_i,
    input  logic             out3_i,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             pass,
    output logic [4:0]       err_count,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid,
    input  logic [VEC_W-1:0] rd_addr,
    output logic [RES_W-1:0] rd_data
);

    // Counter reload: SETTLE runs until the counter has counted down to zero,
    // so loading SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES cycles there.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t              state_r;
    logic [VEC_W-1:0]    vec_idx_r;
    logic [3:0]          settle_cnt_r;
    logic                busy_r;
    logic                done_r;
    logic                aborted_r;
    logic                pass_r;
    logic [4:0]          err_count_r;
    logic [VEC_W-1:0]    first_fail_vec_r;
    logic                first_fail_valid_r;
    logic [RES_W-1:0]    result_r [VEC_COUNT];

    logic [RES_W-1:0]    sample_s;
    logic [RES_W-1:0]    golden_s;
    logic                mismatch_s;
    logic                wr_en_s;

    lab3_golden u_golden (
        .idx      (vec_idx_r),
        .expected (golden_s)
    );

    // Sample word, comparison result and result-file write strobe.
    always_comb begin
        sample_s   = {out1_i, out2_i, out3_i};
        mismatch_s = word_mismatch(sample_s, golden_s);
        if ((state_r == SAMPLE) && !stop) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Sweep sequencer: vector stepping, settle timing, error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= IDLE;
            vec_idx_r          <= 4'd0;
            settle_cnt_r       <= 4'd0;
            busy_r             <= 1'b0;
            done_r             <= 1'b0;
            aborted_r          <= 1'b0;
            pass_r             <= 1'b0;
            err_count_r        <= 5'd0;
            first_fail_vec_r   <= 4'd0;
            first_fail_valid_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // stop has priority over a simultaneous start
                    if (start && !stop) begin
                        state_r            <= SETTLE;
                        vec_idx_r          <= 4'd0;
                        settle_cnt_r       <= SETTLE_LOAD;
                        err_count_r        <= 5'd0;
                        first_fail_vec_r   <= 4'd0;
                        first_fail_valid_r <= 1'b0;
                        pass_r             <= 1'b0;
                        busy_r             <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (stop) begin
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                        aborted_r <= 1'b1;
                    end else if (settle_cnt_r == 4'd0) begin
                        state_r <= SAMPLE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 4'd1;
                    end
                end
                SAMPLE: begin
                    if (stop) begin
                        // abort edge: the sample is discarded
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                        aborted_r <= 1'b1;
                    end else begin
                        if (mismatch_s) begin
                            err_count_r <= err_count_r + 5'd1;
                            if (!first_fail_valid_r) begin
                                first_fail_vec_r   <= vec_idx_r;
                                first_fail_valid_r <= 1'b1;
                            end
                        end
                        if (vec_idx_r == LAST_VEC) begin
                            state_r <= FINISH;
                            busy_r  <= 1'b0;
                        end else begin
                            vec_idx_r    <= vec_idx_r + 4'd1;
                            settle_cnt_r <= SETTLE_LOAD;
                            state_r      <= SETTLE;
                        end
                    end
                end
                FINISH: begin
                    // start is not looked at here, so a held start cannot retrigger
                    done_r  <= 1'b1;
                    pass_r  <= (err_count_r == 5'd0);
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Result file: one captured word per vector, overwritten during each sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VEC_COUNT; i++) begin
                result_r[i] <= 3'b000;
            end
        end else if (wr_en_s) begin
            result_r[vec_idx_r] <= sample_s;
        end
    end

    assign a_o              = vec_idx_r[3];
    assign b_o              = vec_idx_r[2];
    assign c_o              = vec_idx_r[1];
    assign d_o              = vec_idx_r[0];
    assign busy             = busy_r;
    assign done             = done_r;
    assign aborted          = aborted_r;
    assign pass             = pass_r;
    assign err_count        = err_count_r;
    assign first_fail_vec   = first_fail_vec_r;
    assign first_fail_valid = first_fail_valid_r;
    assign rd_data          = result_r[rd_addr];

endmodule

// File: tb/tb_lab3_sweep_ctrl.sv
// Scoreboard bench for lab3_sweep_ctrl. The main instance (SETTLE_CYCLES=2)
// drives a behavioural unit with injectable faults; two further instances
// (SETTLE_CYCLES=1 and 15) check completion latency and vector hold time.
module tb_lab3_sweep_ctrl;

    localparam int S0 = 2;
    localparam int S1 = 1;
    localparam int S2 = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // main instance
    logic       start0, stop0, a0, b0, c0, d0, o1_0, o2_0, o3_0;
    logic       busy0, done0, ab0, pass0, ffval0;
    logic [4:0] err0;
    logic [3:0] ffv0, rd_addr0, v0;
    logic [2:0] rd_data0, u0;
    // latency instances
    logic       start1, stop1, a1, b1, c1, d1, o1_1, o2_1, o3_1;
    logic       busy1, done1, ab1, pass1, ffval1;
    logic [4:0] err1;
    logic [3:0] ffv1, v1;
    logic [2:0] rd_data1;
    logic       start2, stop2, a2, b2, c2, d2, o1_2, o2_2, o3_2;
    logic       busy2, done2, ab2, pass2, ffval2;
    logic [4:0] err2;
    logic [3:0] ffv2, v2;
    logic [2:0] rd_data2;
    logic [3:0] rd_addr12 = 4'd0;

    // behavioural unit fault injection: xor mask per vector, and mask on all
    logic [2:0] xm [16];
    logic [2:0] am;
    logic [2:0] model_res [16];

    function automatic logic [2:0] gold(input logic [3:0] i);
        logic a, b, c, d, g2, g3;
        a = i[3]; b = i[2]; c = i[1]; d = i[0];
        g2 = (a & c) | (b & d);
        g3 = (a | ~c) & (~b | d);
        return {g2 | g3, g2, g3};
    endfunction

    function automatic logic [2:0] uw(input int k);
        return (gold(4'(k)) ^ xm[k]) & am;
    endfunction

    assign v0 = {a0, b0, c0, d0};
    assign v1 = {a1, b1, c1, d1};
    assign v2 = {a2, b2, c2, d2};
    always_comb begin
        u0 = (gold(v0) ^ xm[v0]) & am;
    end
    assign {o1_0, o2_0, o3_0} = u0;
    assign {o1_1, o2_1, o3_1} = gold(v1);
    assign {o1_2, o2_2, o3_2} = gold(v2);

    lab3_sweep_ctrl #(.SETTLE_CYCLES(S0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0),
        .a_o(a0), .b_o(b0), .c_o(c0), .d_o(d0),
        .out1_i(o1_0), .out2_i(o2_0), .out3_i(o3_0),
        .busy(busy0), .done(done0), .aborted(ab0), .pass(pass0),
        .err_count(err0), .first_fail_vec(ffv0), .first_fail_valid(ffval0),
        .rd_addr(rd_addr0), .rd_data(rd_data0));

    lab3_sweep_ctrl #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1),
        .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1),
        .out1_i(o1_1), .out2_i(o2_1), .out3_i(o3_1),
        .busy(busy1), .done(done1), .aborted(ab1), .pass(pass1),
        .err_count(err1), .first_fail_vec(ffv1), .first_fail_valid(ffval1),
        .rd_addr(rd_addr12), .rd_data(rd_data1));

    lab3_sweep_ctrl #(.SETTLE_CYCLES(S2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2),
        .a_o(a2), .b_o(b2), .c_o(c2), .d_o(d2),
        .out1_i(o1_2), .out2_i(o2_2), .out3_i(o3_2),
        .busy(busy2), .done(done2), .aborted(ab2), .pass(pass2),
        .err_count(err2), .first_fail_vec(ffv2), .first_fail_valid(ffval2),
        .rd_addr(rd_addr12), .rd_data(rd_data2));

    typedef struct {
        bit is_done;
        int lat;
        int errs;
        int ffv;
        int ffval;
        int pass;
        int vec;
    } exp_t;

    exp_t q0[$];
    int   q1[$];
    int   q2[$];
    int   t0[3];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Expected outcome of a sweep on the main instance. For an abort, e_edge
    // is the clock edge (counted from the start edge) at which stop is seen.
    task automatic push_expect(input bit is_done, input int e_edge);
        exp_t e;
        int n;
        n = is_done ? 16 : (e_edge - 1) / (S0 + 1);
        e.is_done = is_done;
        e.lat     = e_edge;
        e.errs    = 0;
        e.ffv     = 0;
        e.ffval   = 0;
        for (int k = 0; k < n; k++) begin
            model_res[k] = uw(k);
            if (uw(k) != gold(4'(k))) begin
                if (e.ffval == 0) begin
                    e.ffv   = k;
                    e.ffval = 1;
                end
                e.errs++;
            end
        end
        e.pass = (is_done && e.errs == 0) ? 1 : 0;
        e.vec  = is_done ? 15 : n;
        q0.push_back(e);
    endtask

    task automatic start0_pulse();
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        t0[0] = cyc;
    endtask

    task automatic wait_q0(input int bound);
        int n = 0;
        while (q0.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0) begin
            timeout_fail("main_sweep_event");
            q0.delete();
        end
    endtask

    task automatic read_file();
        for (int k = 0; k < 16; k++) begin
            rd_addr0 = 4'(k);
            #1;
            chk($sformatf("rd_data[%0d]", k), int'(rd_data0), int'(model_res[k]));
        end
    endtask

    task automatic rd_const(input int addr, input int req);
        rd_addr0 = 4'(addr);
        #1;
        chk($sformatf("rd_const[%0d]", addr), int'(rd_data0), req);
    endtask

    task automatic run_full();
        push_expect(1'b1, 16 * (S0 + 1) + 1);
        start0_pulse();
        wait_q0(200);
        read_file();
    endtask

    task automatic run_abort(input int e);
        push_expect(1'b0, e);
        start0_pulse();
        while (cyc < t0[0] + e - 1) @(negedge clk);
        stop0 = 1'b1;
        @(negedge clk);
        stop0 = 1'b0;
        wait_q0(100);
        read_file();
    endtask

    // vector hold-time tracking, used only by the monitor process
    int hold[3];
    int pv[3];
    bit pb[3];
    bit pd0, pa0;

    task automatic stab(input int i, input int s, input logic bz, input logic ab,
                        input logic [3:0] v);
        if (bz && !pb[i]) begin
            chk($sformatf("first_vec inst%0d", i), int'(v), 0);
            hold[i] = 1;
            pv[i] = int'(v);
        end else if (bz) begin
            if (int'(v) == pv[i]) begin
                hold[i]++;
            end else begin
                chk($sformatf("vec_step inst%0d", i), int'(v), pv[i] + 1);
                chk($sformatf("vec_hold inst%0d vec%0d", i, pv[i]), hold[i], s + 1);
                hold[i] = 1;
                pv[i] = int'(v);
            end
        end else if (pb[i] && !ab && pv[i] == 15 && int'(v) == 15) begin
            chk($sformatf("vec_hold inst%0d vec15", i), hold[i], s + 1);
        end
        pb[i] = bz;
    endtask

    // Monitor: pops expectations whenever a DUT reports done or aborted.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            int   lat;
            stab(0, S0, busy0, ab0, v0);
            stab(1, S1, busy1, ab1, v1);
            stab(2, S2, busy2, ab2, v2);
            if (done0 || ab0) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event inst0 actual done=%0d aborted=%0d required none",
                             done0, ab0);
                end else begin
                    e = q0.pop_front();
                    chk("event_kind_done", int'(done0), int'(e.is_done));
                    chk("event_kind_aborted", int'(ab0), int'(!e.is_done));
                    chk("event_latency", cyc - t0[0], e.lat);
                    chk("err_count", int'(err0), e.errs);
                    chk("first_fail_vec", int'(ffv0), e.ffv);
                    chk("first_fail_valid", int'(ffval0), e.ffval);
                    chk("pass", int'(pass0), e.pass);
                    chk("busy_at_event", int'(busy0), 0);
                    chk("vec_at_event", int'(v0), e.vec);
                end
            end
            if (pd0) chk("done_one_cycle", int'(done0), 0);
            if (pa0) chk("aborted_one_cycle", int'(ab0), 0);
            pd0 = done0;
            pa0 = ab0;
            if (done1 || ab1) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event inst1 actual done=%0d required none", done1);
                end else begin
                    lat = q1.pop_front();
                    chk("latency_s1", cyc - t0[1], lat);
                    chk("aborted_s1", int'(ab1), 0);
                    chk("pass_s1", int'(pass1), 1);
                    chk("err_count_s1", int'(err1), 0);
                end
            end
            if (done2 || ab2) begin
                if (q2.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event inst2 actual done=%0d required none", done2);
                end else begin
                    lat = q2.pop_front();
                    chk("latency_s15", cyc - t0[2], lat);
                    chk("aborted_s15", int'(ab2), 0);
                    chk("pass_s15", int'(pass2), 1);
                    chk("err_count_s15", int'(err2), 0);
                end
            end
        end
    end

    initial begin
        int n;
        start0 = 1'b0; stop0 = 1'b0;
        start1 = 1'b0; stop1 = 1'b0;
        start2 = 1'b0; stop2 = 1'b0;
        rd_addr0 = 4'd0;
        am = 3'b111;
        for (int k = 0; k < 16; k++) begin
            xm[k] = 3'b000;
            model_res[k] = 3'b000;
        end
        for (int i = 0; i < 3; i++) begin
            hold[i] = 0; pv[i] = 0; pb[i] = 1'b0;
        end
        pd0 = 1'b0; pa0 = 1'b0;

        // reset state
        #1;
        chk("reset_busy", int'(busy0), 0);
        chk("reset_done", int'(done0), 0);
        chk("reset_err_count", int'(err0), 0);
        chk("reset_first_fail_valid", int'(ffval0), 0);
        chk("reset_pass", int'(pass0), 0);
        chk("reset_vec", int'(v0), 0);
        chk("reset_rd_data", int'(rd_data0), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // fault-free sweep
        run_full();
        rd_const(0, 3'b101);
        rd_const(4, 3'b000);
        rd_const(6, 3'b000);
        rd_const(10, 3'b111);
        rd_const(15, 3'b111);
        chk("fault_free_pass", int'(pass0), 1);

        // out2 stuck at 0
        am = 3'b101;
        run_full();
        chk("stuck_err_count", int'(err0), 7);
        chk("stuck_first_fail_vec", int'(ffv0), 5);
        chk("stuck_first_fail_valid", int'(ffval0), 1);
        chk("stuck_pass", int'(pass0), 0);
        rd_const(15, 3'b101);
        am = 3'b111;

        // stop during vector 6 SETTLE, entries 6..15 keep stuck-at results
        run_abort(6 * (S0 + 1) + 1);
        run_full();

        // start held for the whole sweep
        push_expect(1'b1, 16 * (S0 + 1) + 1);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        t0[0] = cyc;
        n = 0;
        while (!done0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        start0 = 1'b0;
        if (!done0) timeout_fail("held_start_done");
        repeat (5) @(negedge clk);
        chk("held_start_single_sweep", int'(busy0), 0);
        wait_q0(10);

        // start and stop together in IDLE
        @(negedge clk);
        start0 = 1'b1;
        stop0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        stop0 = 1'b0;
        chk("start_stop_idle", int'(busy0), 0);
        repeat (4) @(negedge clk);
        chk("start_stop_idle_later", int'(busy0), 0);

        // randomized fault patterns and abort points
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < 16; k++) begin
                xm[k] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            end
            if ($urandom_range(0, 1) == 1) run_abort($urandom_range(1, 16 * (S0 + 1)));
            else run_full();
        end

        // asynchronous reset during vector 9
        xm[0] = 3'b001;
        start0_pulse();
        while (cyc < t0[0] + 9 * (S0 + 1) + 1) @(negedge clk);
        chk("vec_before_reset", int'(v0), 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", int'(busy0), 0);
        chk("async_reset_err_count", int'(err0), 0);
        chk("async_reset_first_fail_valid", int'(ffval0), 0);
        chk("async_reset_first_fail_vec", int'(ffv0), 0);
        chk("async_reset_pass", int'(pass0), 0);
        chk("async_reset_done", int'(done0), 0);
        chk("async_reset_aborted", int'(ab0), 0);
        chk("async_reset_vec", int'(v0), 0);
        chk("async_reset_rd_s1", int'(rd_data1), 0);
        chk("async_reset_rd_s15", int'(rd_data2), 0);
        for (int k = 0; k < 16; k++) begin
            model_res[k] = 3'b000;
        end
        read_file();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            xm[k] = 3'b000;
        end
        repeat (3) @(negedge clk);
        chk("no_event_after_reset", int'(busy0), 0);
        run_full();

        // latency for SETTLE_CYCLES = 1 and 15
        q1.push_back(16 * (S1 + 1) + 1);
        q2.push_back(16 * (S2 + 1) + 1);
        @(negedge clk);
        start1 = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        t0[1] = cyc;
        t0[2] = cyc;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0) timeout_fail("latency_s1_done");
        if (q2.size() != 0) timeout_fail("latency_s15_done");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lab3_sweep_ctrl.md
Name: lab3_sweep_ctrl

Overview:
Self-test sequencer for the Lab 3 four-input logic unit, whose inputs are a,b,c,d and whose outputs are out1,out2,out3. On `start`, the block:
- drives all 16 input vectors to the unit in order;
- waits a programmable settle time for each vector;
- samples the three outputs and compares them against an internal golden model;
- stores every captured result in a readable 16x3 register file;
- reports pass/fail, error count and the first failing vector.

It sits beside the combinational unit on the board top level and replaces manual switch-toggling.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling. Legal range is 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep. Accepted only in IDLE.
- stop  in  1  abort the sweep in progress.
- a_o  out  1  drive to unit input a; equals vec_idx[3].
- b_o  out  1  drive to unit input b; equals vec_idx[2].
- c_o  out  1  drive to unit input c; equals vec_idx[1].
- d_o  out  1  drive to unit input d; equals vec_idx[0].
- out1_i  in  1  unit output out1.
- out2_i  in  1  unit output out2.
- out3_i  in  1  unit output out3.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- aborted  out  1  one-cycle pulse when a sweep is stopped.
- pass  out  1  high when err_count==0. Valid from done until the next accepted start.
- err_count  out  5  number of mismatching vectors, 0..16.
- first_fail_vec  out  4  index of the lowest failing vector.
- first_fail_valid  out  1  high once any mismatch has been recorded.
- rd_addr  in  4  result file read address.
- rd_data  out  3  {out1,out2,out3} captured for vector rd_addr. Combinational read.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, vec_idx=0, so a_o..d_o=0.
  - busy=0, done=0, aborted=0.
  - err_count=0, first_fail_vec=0, first_fail_valid=0, pass=0.
  - All 16 result entries=3'b000.
  - Reset mid-sweep abandons the sweep; no done or aborted pulse is issued.
- All outputs are registered except rd_data.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - start=1 and stop=0 at an edge -> SETTLE.
  - On that same edge: vec_idx=0, settle_cnt=SETTLE_CYCLES-1, err_count=0, first_fail_valid=0, first_fail_vec=0, pass=0, busy=1.
  - The result file is not cleared; every entry is overwritten during the sweep.
  - start and stop together in IDLE: stop wins and the block stays in IDLE.
- SETTLE: decrement settle_cnt; when it reaches 0, go to SAMPLE.
  - Each vector is therefore held SETTLE_CYCLES cycles in SETTLE plus 1 cycle in SAMPLE.
- SAMPLE, at the edge:
  - result[vec_idx] <= {out1_i,out2_i,out3_i}.
  - If the sample differs from golden(vec_idx): err_count++. If first_fail_valid==0, also set first_fail_vec=vec_idx and first_fail_valid=1.
  - If vec_idx==15 -> FINISH with busy=0.
  - Otherwise vec_idx++ and settle_cnt reloads -> SETTLE. The new vector appears on a_o..d_o on this same edge.
- FINISH: lasts one cycle with done=1; pass=(err_count==0) is registered. Then -> IDLE.
  - start during FINISH is ignored.
- Latency: done goes high 16*(SETTLE_CYCLES+1)+1 cycles after the start edge. For SETTLE_CYCLES=2 this is 49.
- start while busy is ignored.
- stop in SETTLE or SAMPLE:
  - Next edge -> IDLE with busy=0 and aborted=1 for one cycle.
  - The sample is not captured on the abort edge.
  - vec_idx holds its value; err_count and first_fail_* hold partial values.
  - pass stays 0.
- vec_idx does not wrap: a sweep ends at 15.
- Golden model, with a=idx[3], b=idx[2], c=idx[1], d=idx[0]:
  - g2 = a&c | b&d
  - g3 = (a|~c) & (~b|d)
  - g1 = g2 | g3
- Comparison is on the whole 3-bit word; one mismatching vector counts once.

Decomposition:
- Shared package lab3_pkg:
  - state encoding constants: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, FINISH=2'd3;
  - VEC_COUNT=16, VEC_W=4, RES_W=3.
- One natural sub-module: lab3_golden. It is a combinational 4-bit index to 3-bit expected {g1,g2,g3}, instantiated once inside lab3_sweep_ctrl.
- The result file and FSM stay in the top module.

Test Plan:
- Fault-free sweep (bench connects a behavioural unit), SETTLE_CYCLES=2, start pulse -> busy for 48 cycles; done pulses at cycle 49. Then pass=1, err_count=0, first_fail_valid=0, and the result file reads:
  - rd_addr=0 -> 3'b101
  - rd_addr=4 -> 3'b000
  - rd_addr=6 -> 3'b000
  - rd_addr=10 -> 3'b111
  - rd_addr=15 -> 3'b111
- out2 stuck-at-0 injected -> failing vectors are 5, 7, 10, 11, 13, 14, 15. Required: err_count=7, first_fail_vec=5, first_fail_valid=1, pass=0, and rd_addr=15 reads 3'b101.
- stop asserted during vector 6 SETTLE -> aborted pulses one cycle later and busy=0, with no done. The result file holds only entries 0..5 from this sweep. A new start then completes normally.
- start held high for the full sweep, and start+stop asserted together in IDLE -> only one sweep runs, and the simultaneous pulse leaves the block in IDLE.
- rst_n pulsed low during vector 9 -> all outputs return to their reset values immediately (asynchronously), and rd_data=3'b000 for every address.
- SETTLE_CYCLES=1 and SETTLE_CYCLES=15 -> done arrives at cycles 33 and 257 respectively. a_o..d_o must be stable for the full SETTLE_CYCLES+1 window of each vector.
